// File: rtl/inv_cipher.sv
// AES inverse cipher (FIPS-197 InvCipher), iterative, one round per clock.
// Key size is chosen at run time by NR (10/12/14). Round keys come from the
// caller's expanded_key bus, which must stay stable while busy=1.
// Optional build macro: INV_CIPHER_NR_CHECK_EN adds the err port and rejects
// start requests whose NR is not a legal AES round count.
//
// Handshake: start is a request sampled only while busy=0. The accepting edge
// raises busy for the following cycle. Completion is a one-cycle o_valid pulse
// with o_data held until the next completion. A start in the o_valid cycle is
// accepted, so back-to-back blocks are separated by one idle cycle.
module inv_cipher (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    NR,
    input  logic [1919:0] expanded_key,
    input  logic [127:0]  i_data,
    output logic [127:0]  o_data,
    output logic          o_valid,
    output logic          busy
`ifdef INV_CIPHER_NR_CHECK_EN
    ,
    output logic          err
`endif
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm;
    logic [127:0] state_q;
    logic [3:0]   round_ctr;
    logic [3:0]   nr_q;
    logic [127:0] rk_arr [16];
    logic [127:0] round_core;
    logic         nr_ok;

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = INV_SBOX[2047 - 8*int'(s[127-8*i -: 8]) -: 8];
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return r;
    endfunction

    // Split the key bus into round keys; slot 15 is a zero key so any 4-bit index is safe.
    always_comb begin
        for (int k = 0; k < 15; k++)
            rk_arr[k] = expanded_key[1919-128*k -: 128];
        rk_arr[15] = '0;
    end

    // Shared part of every decryption round, keyed by the current round counter.
    always_comb begin
        round_core = add_round_key(inv_sub_bytes(inv_shift_rows(state_q)), rk_arr[round_ctr]);
    end

`ifdef INV_CIPHER_NR_CHECK_EN
    assign nr_ok = (NR == 4'd10) || (NR == 4'd12) || (NR == 4'd14);
`else
    assign nr_ok = 1'b1;
`endif

    // Control FSM, datapath state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            round_ctr <= '0;
            nr_q      <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            busy      <= 1'b0;
`ifdef INV_CIPHER_NR_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
`ifdef INV_CIPHER_NR_CHECK_EN
            err     <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (start) begin
                        if (nr_ok) begin
                            state_q   <= add_round_key(i_data, rk_arr[NR]);
                            nr_q      <= NR;
                            round_ctr <= NR - 4'd1;
                            busy      <= 1'b1;
                            fsm       <= RUN;
                        end
`ifdef INV_CIPHER_NR_CHECK_EN
                        else begin
                            err <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    // The counter is bounded by the latched round count so a
                    // wrapped counter (NR=0) still ends the block promptly.
                    if (round_ctr != 4'd0 && round_ctr < nr_q) begin
                        state_q   <= inv_mix_columns(round_core);
                        round_ctr <= round_ctr - 4'd1;
                    end else begin
                        o_data  <= round_core;
                        o_valid <= 1'b1;
                        busy    <= 1'b0;
                        fsm     <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher.sv
// Directed testbench for inv_cipher using the FIPS-197 appendix C vectors.
// Round keys are produced by a forward key expansion inside the bench.
module tb_inv_cipher;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    NR;
    logic [1919:0] expanded_key;
    logic [127:0]  i_data;
    logic [127:0]  o_data;
    logic          o_valid;
    logic          busy;
`ifdef INV_CIPHER_NR_CHECK_EN
    logic          err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    inv_cipher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .NR           (NR),
        .expanded_key (expanded_key),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .busy         (busy)
`ifdef INV_CIPHER_NR_CHECK_EN
        ,
        .err          (err)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = sbox_tbl[2047 - 8*int'(w[31-8*i -: 8]) -: 8];
        return r;
    endfunction

    // FIPS-197 key expansion; key is left-aligned in 256 bits.
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ek;
        rc = 8'h01;
        ek = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) ek[1919-32*i -: 32] = w[i];
        return ek;
    endfunction

    // Driver: present start for one cycle from a falling edge; returns at the
    // falling edge just after the accepting rising edge.
    task automatic launch(input logic [127:0] ct, input logic [3:0] nr);
        i_data = ct;
        NR     = nr;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Driver: count rising edges since acceptance until o_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        NR    = 4'd10;
        i_data = '0;
        expanded_key = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_tests++;
        if (o_data !== 128'h0) begin n_fail++; $display("FAIL reset_o_data: got %h want 0", o_data); end
`ifdef INV_CIPHER_NR_CHECK_EN
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        int lat;
        expanded_key = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL aes128_busy: got %b want 1", busy); end
        NR = 4'd14;  // must be ignored while busy
        wait_valid(lat);
        n_tests++;
        if (lat !== 10) begin n_fail++; $display("FAIL aes128_latency: got %0d want 10", lat); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL aes128_data: got %h want %h", o_data, PT); end
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL aes128_pulse: got %b want 0", o_valid); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL aes128_hold: got %h want %h", o_data, PT); end
    endtask

    task automatic test_aes192();
        int lat;
        expanded_key = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
        launch(128'hdda97ca4864cdfe06eaf70a0ec0d7191, 4'd12);
        wait_valid(lat);
        n_tests++;
        if (lat !== 12) begin n_fail++; $display("FAIL aes192_latency: got %0d want 12", lat); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL aes192_data: got %h want %h", o_data, PT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        expanded_key = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        launch(128'h8ea2b7ca516745bfeafc49904b496089, 4'd14);
        wait_valid(lat);
        n_tests++;
        if (lat !== 14) begin n_fail++; $display("FAIL aes256_latency: got %0d want 14", lat); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL aes256_data: got %h want %h", o_data, PT); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL aes256_busy_at_valid: got %b want 0", busy); end
        // second start in the o_valid cycle
        launch(128'h8ea2b7ca516745bfeafc49904b496089, 4'd14);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        wait_valid(lat);
        n_tests++;
        if (lat !== 14) begin n_fail++; $display("FAIL b2b_latency: got %0d want 14", lat); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL b2b_data: got %h want %h", o_data, PT); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int seen;
        expanded_key = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10);
        seen = 0;
        // cycles 1..2
        repeat (2) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        // cycle 3: start while busy
        launch(128'hdeadbeef0123456789abcdeffedcba98, 4'd12);
        // cycles 4..5
        repeat (2) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before_reset: got %b want 1", busy); end
        // cycle 6: reset with a coincident start
        rst_n  = 1'b0;
        start  = 1'b1;
        i_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        NR     = 4'd10;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++;
        if (o_data !== 128'h0) begin n_fail++; $display("FAIL abort_o_data: got %h want 0", o_data); end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_after: got %b want 0", busy); end
    endtask

`ifdef INV_CIPHER_NR_CHECK_EN
    task automatic test_nr_check();
        int lat;
        int seen;
        logic [127:0] held;
        held = o_data;
        seen = 0;
        launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd11);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL nrchk_err: got %b want 1", err); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nrchk_busy: got %b want 0", busy); end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL nrchk_err_pulse: got %b want 0", err); end
        repeat (14) begin
            if (o_valid || busy) seen++;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL nrchk_idle: got %0d active cycles want 0", seen); end
        n_tests++;
        if (o_data !== held) begin n_fail++; $display("FAIL nrchk_o_data: got %h want %h", o_data, held); end
        launch(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10);
        wait_valid(lat);
        n_tests++;
        if (lat !== 10) begin n_fail++; $display("FAIL nrchk_legal_latency: got %0d want 10", lat); end
        n_tests++;
        if (o_data !== PT) begin n_fail++; $display("FAIL nrchk_legal_data: got %h want %h", o_data, PT); end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_aes128();
        test_aes192();
        test_back_to_back();
        test_abort();
`ifdef INV_CIPHER_NR_CHECK_EN
        test_nr_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_cipher.md
INV_CIPHER -- requirements
Module: inv_cipher

Interface
REQ-001 Parameters: none; key size is selected at run time by NR.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to decrypt i_data; sampled only while busy=0.
REQ-005 NR  input  4  round count; legal values 10 (AES-128), 12 (AES-192), 14 (AES-256).
REQ-006 expanded_key  input  1920  round keys; round key k occupies [1919-128*k -: 128], so key 0 is [1919:1792].
REQ-007 i_data  input  128  ciphertext block, FIPS-197 byte order with byte 0 at [127:120].
REQ-008 o_data  output  128  plaintext block; valid while o_valid=1 and held until the next completion.
REQ-009 o_valid  output  1  one-cycle pulse marking a completed block.
REQ-010 busy  output  1  high while a block is in progress.
REQ-011 err  output  1  one-cycle pulse on an illegal NR; exists only with INV_CIPHER_NR_CHECK_EN.

Function
REQ-012 The block SHALL implement the FIPS-197 InvCipher, iterative, one round per clock.
REQ-013 FSM states SHALL be IDLE and RUN.
REQ-014 IDLE with start=1 SHALL, at that edge:
- load state <= i_data XOR rk[NR];
- latch NR into nr_q;
- load round_ctr <= NR-1;
- enter RUN, with busy=1 from the next cycle.
REQ-015 RUN with round_ctr>0 SHALL load state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[round_ctr])) and decrement round_ctr.
REQ-016 RUN with round_ctr==0 SHALL:
- load o_data <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]);
- pulse o_valid for one cycle;
- return to IDLE.
REQ-017 Latency: o_valid SHALL be high in the cycle beginning NR rising edges after the edge that accepted start (10/12/14 cycles).
REQ-018 expanded_key SHALL be held stable by the user while busy=1; it is not latched internally.
REQ-019 start while busy=1 SHALL be ignored, with no effect on state, nr_q or round_ctr.
REQ-020 start in the same cycle o_valid is asserted SHALL be accepted, giving back-to-back blocks with one IDLE cycle between them.
REQ-021 Changes to the NR input while busy=1 SHALL have no effect; nr_q is used.
REQ-022 Round transforms SHALL be combinational helpers (inv_sub_bytes, inv_shift_rows, inv_mix_columns, plus the existing add_round_key); only state, round_ctr, nr_q, FSM and outputs are registered.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force: FSM to IDLE, busy=0, o_valid=0, err=0, o_data=128'h0, round_ctr=0, nr_q=0.
REQ-024 Reset asserted mid-operation SHALL abort the block with no o_valid pulse; o_data reads 0.
REQ-025 start coincident with rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro INV_CIPHER_NR_CHECK_EN SHALL select NR legality checking.
REQ-027 With INV_CIPHER_NR_CHECK_EN defined, start in IDLE with NR not in {10,12,14} SHALL:
- pulse err for one cycle;
- stay in IDLE;
- leave o_data unchanged;
- produce no o_valid.
REQ-028 Without INV_CIPHER_NR_CHECK_EN, the err port SHALL be absent and NR SHALL be used unchecked; results for illegal NR are undefined but the FSM SHALL still return to IDLE after NR round cycles.

Verification
REQ-029 AES-128: key 000102..0f expanded, NR=10, i_data 69c4e0d86a7b0430d8cdb78070b4c55a -> o_data 00112233445566778899aabbccddeeff, o_valid exactly 10 cycles after start.
REQ-030 AES-192: key 000102..17, NR=12, i_data dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, latency 12.
REQ-031 AES-256: key 000102..1f, NR=14, i_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, latency 14; and a second start pulsed at the o_valid cycle -> second correct result 14 cycles later.
REQ-032 Start AES-128 block, pulse start with other data at cycle 3, then drop rst_n at cycle 6 -> cycle-3 start ignored, no o_valid, busy=0 and o_data=0 after the reset edge.
REQ-033 With INV_CIPHER_NR_CHECK_EN, start with NR=11 -> err=1 for one cycle, busy stays 0, no o_valid; a following legal start decrypts correctly.
